// File: rtl/rv32_alu_issue_pkg.sv
// rv32_alu_issue_pkg -- shared constants and types for the RV32 ALU issue path.
//   ALU_*   : 4-bit ALU operation codes (also consumed by the ALU itself)
//   OPC_*   : RV32I major opcodes
//   buf_state_e : issue buffer occupancy (encoding equals entry count)
//   dec_entry_t : one decoded entry as it sits in the issue buffer
package rv32_alu_issue_pkg;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b1000;
  localparam logic [3:0] ALU_SLL   = 4'b0001;
  localparam logic [3:0] ALU_SLT   = 4'b0010;
  localparam logic [3:0] ALU_SLTU  = 4'b1010;
  localparam logic [3:0] ALU_PASSB = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SRL   = 4'b0101;
  localparam logic [3:0] ALU_SRA   = 4'b1101;
  localparam logic [3:0] ALU_OR    = 4'b0110;
  localparam logic [3:0] ALU_AND   = 4'b0111;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Encoding doubles as the number of valid entries.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_e;

  typedef struct packed {
    logic [31:0] da;
    logic [31:0] db;
    logic [3:0]  aluctr;
    logic [4:0]  rd;
    logic        illegal;
  } dec_entry_t;

  // Register/immediate arithmetic code from funct3; alt picks sub/sra.
  function automatic logic [3:0] alu_code(input logic [2:0] f3, input logic alt);
    logic [3:0] c;
    case (f3)
      3'b000:  c = alt ? ALU_SUB : ALU_ADD;
      3'b001:  c = ALU_SLL;
      3'b010:  c = ALU_SLT;
      3'b011:  c = ALU_SLTU;
      3'b100:  c = ALU_XOR;
      3'b101:  c = alt ? ALU_SRA : ALU_SRL;
      3'b110:  c = ALU_OR;
      default: c = ALU_AND;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rv32_alu_issue_if.sv
// rv32_alu_issue_if -- bundle of the issue block's upstream and ALU-side
// handshakes.
//   master : instruction source / ALU consumer side (drives in_*, out_ready)
//   slave  : issue block side (drives in_ready, out_*)
interface rv32_alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_da;
  logic [31:0] out_db;
  logic [3:0]  out_aluctr;
  logic [4:0]  out_rd;
  logic        out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, in_rs1, in_rs2, out_ready,
    input  in_ready, out_valid, out_da, out_db, out_aluctr, out_rd, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, in_rs1, in_rs2, out_ready,
    output in_ready, out_valid, out_da, out_db, out_aluctr, out_rd, out_illegal
  );
endinterface

// File: rtl/rv32_alu_decode.sv
// rv32_alu_decode -- combinational RV32I decode into ALU operands/opcode.
//   instr, pc, rs1, rs2 : instruction word, its address, register operands
//   dec                 : decoded entry (da, db, aluctr, rd, illegal)
// Unsupported encodings produce illegal=1 with zero operands, add, rd=0.
module rv32_alu_decode
  import rv32_alu_issue_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output dec_entry_t  dec
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic        f7b5;
  logic [4:0]  rd;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_u;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign f7b5   = instr[30];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u  = {instr[31:12], 12'b0};

  always_comb begin
    dec        = '0;
    dec.aluctr = ALU_ADD;
    case (opcode)
      OPC_OP: begin
        dec.da     = rs1;
        dec.db     = rs2;
        dec.aluctr = alu_code(f3, f7b5 & ((f3 == 3'b000) | (f3 == 3'b101)));
        dec.rd     = rd;
      end
      OPC_OPIMM: begin
        // instr[30] is immediate data for addi, so only srai uses it.
        dec.da     = rs1;
        dec.db     = imm_i;
        dec.aluctr = alu_code(f3, f7b5 & (f3 == 3'b101));
        dec.rd     = rd;
      end
      OPC_LUI: begin
        dec.db     = imm_u;
        dec.aluctr = ALU_PASSB;
        dec.rd     = rd;
      end
      OPC_AUIPC: begin
        dec.da = pc;
        dec.db = imm_u;
        dec.rd = rd;
      end
      OPC_LOAD: begin
        dec.da = rs1;
        dec.db = imm_i;
        dec.rd = rd;
      end
      OPC_STORE: begin
        dec.da = rs1;
        dec.db = imm_s;
      end
      OPC_BRANCH: begin
        case (f3)
          3'b000, 3'b001: begin dec.da = rs1; dec.db = rs2; dec.aluctr = ALU_SUB;  end
          3'b100, 3'b101: begin dec.da = rs1; dec.db = rs2; dec.aluctr = ALU_SLT;  end
          3'b110, 3'b111: begin dec.da = rs1; dec.db = rs2; dec.aluctr = ALU_SLTU; end
          default:        dec.illegal = 1'b1;
        endcase
      end
      OPC_JAL, OPC_JALR: begin
        // ALU computes the link value pc+4.
        dec.da = pc;
        dec.db = 32'd4;
        dec.rd = rd;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv32_alu_issue.sv
// rv32_alu_issue -- decodes RV32I instructions and buffers up to two decoded
// entries in front of the ALU.
//   clk, rst_n        : clock, synchronous active-low reset
//   in_valid/in_ready : upstream handshake; in_instr, in_pc, in_rs1, in_rs2
//   out_valid/out_ready : ALU-side handshake; out_da, out_db, out_aluctr,
//                       out_rd, out_illegal describe the head entry
// Outputs come straight from the head register, so an entry accepted into an
// empty buffer appears one cycle later and stays stable under backpressure.
module rv32_alu_issue
  import rv32_alu_issue_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_da,
  output logic [31:0] out_db,
  output logic [3:0]  out_aluctr,
  output logic [4:0]  out_rd,
  output logic        out_illegal
);

  buf_state_e state_q, state_d;
  dec_entry_t head_q, head_d;
  dec_entry_t tail_q, tail_d;
  logic       in_ready_q, in_ready_d;
  dec_entry_t dec;
  logic       acc, drn;

  rv32_alu_decode u_decode (
    .instr (in_instr),
    .pc    (in_pc),
    .rs1   (in_rs1),
    .rs2   (in_rs2),
    .dec   (dec)
  );

  assign acc = in_valid & in_ready_q;
  assign drn = (state_q != ST_EMPTY) & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      ST_EMPTY: begin
        if (acc) begin
          head_d  = dec;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        case ({acc, drn})
          2'b10: begin tail_d = dec; state_d = ST_TWO;   end
          2'b01: begin head_d = '0;  state_d = ST_EMPTY; end
          2'b11: head_d = dec;
          default: ;
        endcase
      end
      ST_TWO: begin
        // in_ready is low here, so only a drain can happen.
        if (drn) begin
          head_d  = tail_q;
          tail_d  = '0;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Registered ready: computed from next occupancy so it drops the cycle
    // the buffer becomes full.
    in_ready_d = int'(state_d) < DEPTH;
  end

  always_comb begin
    in_ready    = in_ready_q;
    out_valid   = (state_q != ST_EMPTY);
    out_da      = head_q.da;
    out_db      = head_q.db;
    out_aluctr  = head_q.aluctr;
    out_rd      = head_q.rd;
    out_illegal = head_q.illegal;
  end

endmodule

// File: tb/tb_rv32_alu_issue.sv
// Bench for rv32_alu_issue: directed cases plus random traffic checked
// against a queue-based reference of decoded entries.
module tb_rv32_alu_issue;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rv32_alu_issue_if bus ();

  rv32_alu_issue #(.DEPTH(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (bus.in_valid),
    .in_ready    (bus.in_ready),
    .in_instr    (bus.in_instr),
    .in_pc       (bus.in_pc),
    .in_rs1      (bus.in_rs1),
    .in_rs2      (bus.in_rs2),
    .out_valid   (bus.out_valid),
    .out_ready   (bus.out_ready),
    .out_da      (bus.out_da),
    .out_db      (bus.out_db),
    .out_aluctr  (bus.out_aluctr),
    .out_rd      (bus.out_rd),
    .out_illegal (bus.out_illegal)
  );

  typedef struct {
    logic [31:0] da;
    logic [31:0] db;
    logic [3:0]  alu;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Reference decode straight from the instruction-set rules.
  function automatic exp_t ref_dec(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] a, input logic [31:0] b);
    exp_t       e;
    logic [3:0] tab [8];
    logic [2:0] f3;
    logic       alt;
    logic [31:0] imm_i, imm_s, imm_u;
    tab   = '{4'h0, 4'h1, 4'h2, 4'hA, 4'h4, 4'h5, 4'h6, 4'h7};
    f3    = ins[14:12];
    alt   = ins[30];
    imm_i = {{20{ins[31]}}, ins[31:20]};
    imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    imm_u = {ins[31:12], 12'h000};
    e = '{32'h0, 32'h0, 4'h0, 5'h0, 1'b0};
    case (ins[6:0])
      7'h33: begin
        e.da = a; e.db = b; e.rd = ins[11:7];
        e.alu = (f3 == 3'd0 && alt) ? 4'h8 : (f3 == 3'd5 && alt) ? 4'hD : tab[f3];
      end
      7'h13: begin
        e.da = a; e.db = imm_i; e.rd = ins[11:7];
        e.alu = (f3 == 3'd5 && alt) ? 4'hD : tab[f3];
      end
      7'h37: begin e.db = imm_u; e.alu = 4'h3; e.rd = ins[11:7]; end
      7'h17: begin e.da = pc; e.db = imm_u; e.rd = ins[11:7]; end
      7'h03: begin e.da = a; e.db = imm_i; e.rd = ins[11:7]; end
      7'h23: begin e.da = a; e.db = imm_s; end
      7'h63: begin
        if (f3 == 3'd2 || f3 == 3'd3) e.ill = 1'b1;
        else begin
          e.da = a; e.db = b;
          e.alu = !f3[2] ? 4'h8 : (f3[1] ? 4'hA : 4'h2);
        end
      end
      7'h6F, 7'h67: begin e.da = pc; e.db = 32'd4; e.rd = ins[11:7]; end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  ops [10];
    ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h13};
    w = $urandom;
    if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 9)];
    return w;
  endfunction

  task automatic cmp_model();
    chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
    chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
    if (q.size() > 0) begin
      chk("out_da", bus.out_da, q[0].da);
      chk("out_db", bus.out_db, q[0].db);
      chk("out_aluctr", 32'(bus.out_aluctr), 32'(q[0].alu));
      chk("out_rd", 32'(bus.out_rd), 32'(q[0].rd));
      chk("out_illegal", 32'(bus.out_illegal), 32'(q[0].ill));
    end
  endtask

  // One clock: drive at the falling edge, update model at the rising edge,
  // compare at the next falling edge.
  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b, input logic ordy);
    logic acc, drn;
    bus.in_valid = v;
    bus.in_instr = ins;
    bus.in_pc    = pc;
    bus.in_rs1   = a;
    bus.in_rs2   = b;
    bus.out_ready = ordy;
    acc = v && (q.size() < 2);
    drn = ordy && (q.size() > 0);
    @(posedge clk);
    if (drn) void'(q.pop_front());
    if (acc) q.push_back(ref_dec(ins, pc, a, b));
    @(negedge clk);
    cmp_model();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_da"}, bus.out_da, 32'd0);
    chk({tag, "_db"}, bus.out_db, 32'd0);
    chk({tag, "_alu"}, 32'(bus.out_aluctr), 32'd0);
    chk({tag, "_rd"}, 32'(bus.out_rd), 32'd0);
    chk({tag, "_ill"}, 32'(bus.out_illegal), 32'd0);
  endtask

  initial begin
    // Reset with in_valid high: the instruction must be ignored.
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h00500093;
    bus.in_pc     = 32'h0;
    bus.in_rs1    = 32'h0;
    bus.in_rs2    = 32'h0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("rst");
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);

    // addi x1,x0,5
    drive(1'b1, 32'h00500093, 32'h100, 32'd0, 32'd0, 1'b1);
    chk("addi_valid", 32'(bus.out_valid), 32'd1);
    chk("addi_da", bus.out_da, 32'd0);
    chk("addi_db", bus.out_db, 32'd5);
    chk("addi_alu", 32'(bus.out_aluctr), 32'h0);
    chk("addi_rd", 32'(bus.out_rd), 32'd1);

    // sub x3,x1,x2 accepted while addi drains
    drive(1'b1, 32'h402081B3, 32'h104, 32'd9, 32'd4, 1'b1);
    chk("sub_alu", 32'(bus.out_aluctr), 32'h8);
    chk("sub_da", bus.out_da, 32'd9);
    chk("sub_db", bus.out_db, 32'd4);
    chk("sub_rd", 32'(bus.out_rd), 32'd3);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);

    // Backpressure: fill, attempt a third, drain in order.
    drive(1'b1, 32'h00500093, 32'h200, 32'd0, 32'd0, 1'b0);
    drive(1'b1, 32'h00700113, 32'h204, 32'd0, 32'd0, 1'b0);
    chk("bp_full_ready", 32'(bus.in_ready), 32'd0);
    drive(1'b1, 32'h00900193, 32'h208, 32'd0, 32'd0, 1'b0);
    chk("bp_hold_rd", 32'(bus.out_rd), 32'd1);
    chk("bp_hold_db", bus.out_db, 32'd5);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    chk("bp_second_rd", 32'(bus.out_rd), 32'd2);
    chk("bp_second_db", bus.out_db, 32'd7);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    chk("bp_third_dropped", 32'(bus.out_valid), 32'd0);

    // lui x5,0x12345
    drive(1'b1, 32'h123452B7, 32'h300, 32'hAAAA, 32'hBBBB, 1'b1);
    chk("lui_da", bus.out_da, 32'h0);
    chk("lui_db", bus.out_db, 32'h12345000);
    chk("lui_alu", 32'(bus.out_aluctr), 32'h3);
    chk("lui_rd", 32'(bus.out_rd), 32'd5);
    // bltu x1,x2,0
    drive(1'b1, 32'h0020E063, 32'h304, 32'd11, 32'd22, 1'b1);
    chk("bltu_alu", 32'(bus.out_aluctr), 32'hA);
    chk("bltu_rd", 32'(bus.out_rd), 32'd0);
    chk("bltu_da", bus.out_da, 32'd11);
    chk("bltu_db", bus.out_db, 32'd22);

    // Illegal opcode still flows through.
    drive(1'b1, 32'hFFFFFFFF, 32'h308, 32'd5, 32'd6, 1'b1);
    chk("ill_flag", 32'(bus.out_illegal), 32'd1);
    chk("ill_da", bus.out_da, 32'd0);
    chk("ill_db", bus.out_db, 32'd0);
    chk("ill_rd", 32'(bus.out_rd), 32'd0);
    chk("ill_alu", 32'(bus.out_aluctr), 32'd0);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    chk("ill_drained", 32'(bus.out_valid), 32'd0);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom, $urandom,
            $urandom_range(0, 2) != 0);

    // Reset while full.
    repeat (3) drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    drive(1'b1, 32'h00500093, 32'h400, 32'd0, 32'd0, 1'b0);
    drive(1'b1, 32'h00700113, 32'h404, 32'd0, 32'd0, 1'b0);
    chk("two_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    q.delete();
    @(negedge clk);
    chk_all_zero("rst2");
    rst_n = 1'b1;
    repeat (3) drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/rv32_alu_issue.md
RV32_ALU_ISSUE -- requirements
Module: rv32_alu_issue

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of buffered decoded entries (fixed at 2; other values unsupported).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  upstream presents an instruction.
REQ-005 SHALL have port in_ready  output  1  block can accept; registered.
REQ-006 SHALL have port in_instr  input  32  RV32I instruction word.
REQ-007 SHALL have port in_pc  input  32  instruction address.
REQ-008 SHALL have ports in_rs1 and in_rs2  input  32 each  register-file operands.
REQ-009 SHALL have port out_valid  output  1  decoded entry available to ALU.
REQ-010 SHALL have port out_ready  input  1  ALU stage consumes entry.
REQ-011 SHALL have ports out_da and out_db  output  32 each  ALU operands.
REQ-012 SHALL have port out_aluctr  output  4  ALU operation code.
REQ-013 SHALL have port out_rd  output  5  destination register, 0 when none.
REQ-014 SHALL have port out_illegal  output  1  unsupported opcode flag.

Function
REQ-015 SHALL accept on in_valid&in_ready and transfer out on out_valid&out_ready.
REQ-016 SHALL present an accepted instruction on out_* exactly 1 cycle after acceptance when the buffer was empty.
REQ-017 SHALL hold a two-entry buffer with states EMPTY, ONE, TWO: accept-only advances, drain-only retreats, accept+drain holds.
REQ-018 SHALL drive in_ready=0 only in TWO, so no transfer is lost when out_ready drops.
REQ-019 SHALL keep out_* stable while out_valid=1 and out_ready=0.
REQ-020 SHALL deliver entries in acceptance order (FIFO).
REQ-021 SHALL use aluctr codes: add 0000, sub 1000, sll 0001, slt 0010, sltu 1010, passB 0011, xor 0100, srl 0101, sra 1101, or 0110, and 0111.
REQ-022 SHALL decode OP (0110011): da=rs1, db=rs2, code per funct3 with funct7[5] selecting sub/sra.
REQ-023 SHALL decode OP-IMM (0010011): da=rs1, db=sign-extended imm[11:0]; funct7[5] selects sra only for funct3=101.
REQ-024 SHALL decode LUI: da=0, db={imm[31:12],12'b0}, passB; AUIPC: da=pc, db=same imm, add.
REQ-025 SHALL decode LOAD/STORE: da=rs1, db=sign-extended I/S immediate, add; STORE and BRANCH give rd=0.
REQ-026 SHALL decode BRANCH: da=rs1, db=rs2; beq/bne sub, blt/bge slt, bltu/bgeu sltu.
REQ-027 SHALL decode JAL/JALR: da=pc, db=32'd4, add (link value).
REQ-028 SHALL flag any other opcode, or funct3 010/011 in BRANCH: out_illegal=1, da=db=0, add, rd=0; entry still flows through handshake.
REQ-029 SHALL ignore in_* when in_valid=0 or in_ready=0.

Reset
REQ-030 SHALL, on clk edge with rst_n=0, go to EMPTY: out_valid=0, in_ready=1, out_da=out_db=0, out_aluctr=0000, out_rd=0, out_illegal=0.
REQ-031 SHALL discard buffered entries on reset mid-operation; no entry appears after rst_n returns high.
REQ-032 SHALL ignore in_valid in the cycle rst_n=0.

Structure
REQ-033 SHALL place aluctr code constants and RV32 opcode constants in a shared package used by the ALU and this block.
REQ-034 SHALL implement decode as one combinational sub-module rv32_alu_decode feeding the buffer registers.

Verification
REQ-035 SHALL test: reset, then in_instr=0x00500093 (addi x1,x0,5), rs1=0, out_ready=1 -> next cycle out_da=0, out_db=5, aluctr=0000, rd=1.
REQ-036 SHALL test: sub x3,x1,x2 (0x402081B3), rs1=9, rs2=4 -> aluctr=1000, da=9, db=4, rd=3.
REQ-037 SHALL test: out_ready=0, two accepts -> in_ready=0 after second; third in_valid not accepted; raising out_ready drains both in order.
REQ-038 SHALL test: lui x5,0x12345 (0x123452B7) -> da=0, db=0x12345000, aluctr=0011; bltu (funct3=110) -> aluctr=1010, rd=0.
REQ-039 SHALL test: instr=0xFFFFFFFF -> out_illegal=1, da=db=0, rd=0, handshake completes.
REQ-040 SHALL test: rst_n=0 while in TWO -> next cycle out_valid=0, in_ready=1, all outputs zero.
